// File: rtl/fc_dec_pkg.sv
// Shared definitions for the FC-layer spike decoder.
//   state_t      : decoder FSM states
//   *_DEF        : default geometry (classes, timesteps, counter and membrane widths)
//   ID_W         : width of the class_id result
package fc_dec_pkg;

    localparam int unsigned N_CLASS_DEF = 10;
    localparam int unsigned T_STEPS_DEF = 8;
    localparam int unsigned CNT_W_DEF   = 4;
    localparam int unsigned V_W_DEF     = 16;
    localparam int unsigned ID_W        = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCAN  = 2'd2
    } state_t;

endpackage

// File: rtl/fc_spike_decoder_if.sv
// Spike/membrane stream from the FC activation stage into the decoder.
//   s_valid : beat valid (master)
//   s_ready : decoder accepts beats (slave)
//   s_in    : one spike bit per class
//   v_in    : packed membranes, class i at [V_W*(i+1)-1 : V_W*i]
interface fc_spike_decoder_if #(
    parameter int unsigned N_CLASS = fc_dec_pkg::N_CLASS_DEF,
    parameter int unsigned V_W     = fc_dec_pkg::V_W_DEF
);
    logic                   s_valid;
    logic                   s_ready;
    logic [N_CLASS-1:0]     s_in;
    logic [N_CLASS*V_W-1:0] v_in;

    modport master (output s_valid, output s_in, output v_in, input s_ready);
    modport slave  (input s_valid, input s_in, input v_in, output s_ready);
endinterface

// File: rtl/spike_cnt_sat.sv
// One saturating spike counter.
//   clk, rst   : clock, async active-high reset
//   clr        : synchronous clear (wins over inc)
//   inc        : add one unless already at the maximum
//   cnt        : registered count
//   cnt_next_c : value cnt takes on the next edge
module spike_cnt_sat #(
    parameter int unsigned CNT_W = fc_dec_pkg::CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_next_c
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Next value: clear, saturating increment, or hold.
    always_comb begin
        cnt_next_c = cnt;
        if (clr) begin
            cnt_next_c = '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt_next_c = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next_c;
        end
    end
endmodule

// File: rtl/fc_spike_decoder.sv
// Spike-count classifier for the fully-connected spiking output layer.
// Counts spikes per class over T_STEPS beats, then scans the classes one per
// cycle to pick the winner (highest count, then highest final membrane,
// then lowest index).
//   clk, rst  : clock, async active-high reset
//   start     : begin a new image (aborts any image in flight)
//   spk       : spike/membrane stream (slave side)
//   busy      : image in progress (ACCUM or SCAN)
//   done      : one-cycle result strobe
//   class_id  : winning class, held until the next done
//   class_cnt : spike count of the winner
module fc_spike_decoder
    import fc_dec_pkg::*;
#(
    parameter int unsigned N_CLASS = N_CLASS_DEF,
    parameter int unsigned T_STEPS = T_STEPS_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned V_W     = V_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    fc_spike_decoder_if.slave spk,
    output logic              busy,
    output logic              done,
    output logic [ID_W-1:0]   class_id,
    output logic [CNT_W-1:0]  class_cnt
);
    localparam int unsigned       STEP_W    = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(T_STEPS - 1);
    localparam logic [ID_W-1:0]   IDX_LAST  = ID_W'(N_CLASS - 1);

    state_t                 state, state_d;
    logic [STEP_W-1:0]      step, step_d;
    logic [ID_W-1:0]        idx, idx_d;
    logic [ID_W-1:0]        best_idx, best_idx_d;
    logic [CNT_W-1:0]       best_cnt, best_cnt_d;
    logic signed [V_W-1:0]  best_v, best_v_d;
    logic signed [V_W-1:0]  v_last [N_CLASS];
    logic signed [V_W-1:0]  v_last_d [N_CLASS];
    logic signed [V_W-1:0]  v_in_arr [N_CLASS];
    logic [CNT_W-1:0]       cnt [N_CLASS];
    logic [CNT_W-1:0]       cnt_next [N_CLASS];
    logic [ID_W-1:0]        class_id_d;
    logic [CNT_W-1:0]       class_cnt_d;
    logic                   ready, ready_d, busy_d, done_d;
    logic                   beat_c;
    logic [N_CLASS-1:0]     inc_c;
    logic [CNT_W-1:0]       cand_cnt;
    logic signed [V_W-1:0]  cand_v;
    logic                   cand_wins;

    assign spk.s_ready = ready;

    // A beat counts only in ACCUM and never in a start cycle.
    assign beat_c = (state == ACCUM) && spk.s_valid && !start;
    assign inc_c  = {N_CLASS{beat_c}} & spk.s_in;

    for (genvar g = 0; g < N_CLASS; g++) begin : g_cnt
        spike_cnt_sat #(.CNT_W(CNT_W)) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .clr        (start),
            .inc        (inc_c[g]),
            .cnt        (cnt[g]),
            .cnt_next_c (cnt_next[g])
        );
    end

    // Unpack the membrane bus into per-class signed values.
    always_comb begin
        for (int i = 0; i < N_CLASS; i++) begin
            v_in_arr[i] = spk.v_in[i*V_W +: V_W];
        end
    end

    // Scan comparator: strict greater keeps the lower index on a full tie.
    assign cand_cnt  = cnt[idx];
    assign cand_v    = v_last[idx];
    assign cand_wins = (cand_cnt > best_cnt) ||
                       ((cand_cnt == best_cnt) && (cand_v > best_v));

    // Next-state and datapath next values.
    always_comb begin
        state_d     = state;
        step_d      = step;
        idx_d       = idx;
        best_idx_d  = best_idx;
        best_cnt_d  = best_cnt;
        best_v_d    = best_v;
        v_last_d    = v_last;
        class_id_d  = class_id;
        class_cnt_d = class_cnt;
        done_d      = 1'b0;

        if (start) begin
            state_d = ACCUM;
            step_d  = '0;
            idx_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                end
                ACCUM: begin
                    if (spk.s_valid) begin
                        if (step == STEP_LAST) begin
                            // Class 0 seeds the scan, using its count including this beat.
                            state_d    = SCAN;
                            step_d     = '0;
                            idx_d      = ID_W'(1);
                            best_idx_d = '0;
                            best_cnt_d = cnt_next[0];
                            best_v_d   = v_in_arr[0];
                            v_last_d   = v_in_arr;
                        end else begin
                            step_d = step + STEP_W'(1);
                        end
                    end
                end
                SCAN: begin
                    if (cand_wins) begin
                        best_idx_d = idx;
                        best_cnt_d = cand_cnt;
                        best_v_d   = cand_v;
                    end
                    if (idx == IDX_LAST) begin
                        state_d     = IDLE;
                        idx_d       = '0;
                        done_d      = 1'b1;
                        class_id_d  = best_idx_d;
                        class_cnt_d = best_cnt_d;
                    end else begin
                        idx_d = idx + ID_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        ready_d = (state_d == ACCUM);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            step      <= '0;
            idx       <= '0;
            best_idx  <= '0;
            best_cnt  <= '0;
            best_v    <= '0;
            v_last    <= '{default: '0};
            class_id  <= '0;
            class_cnt <= '0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            step      <= step_d;
            idx       <= idx_d;
            best_idx  <= best_idx_d;
            best_cnt  <= best_cnt_d;
            best_v    <= best_v_d;
            v_last    <= v_last_d;
            class_id  <= class_id_d;
            class_cnt <= class_cnt_d;
            ready     <= ready_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end
endmodule

// File: doc/fc_spike_decoder.md
# fc_spike_decoder

- Output-side reader for the 10-class fully-connected spiking layer.
- Consumes the per-timestep spike vector and final membrane potentials produced by the FC activation stage.
- Accumulates per-class spike counts over a fixed number of timesteps, then scans the counts sequentially to produce the winning class index.
- Sits between the FC layer's spike/membrane outputs and the classification result register.

## Interface

Parameters:
- N_CLASS, 10, number of output neurons/classes
- T_STEPS, 8, timesteps per image (≥2)
- CNT_W, 4, spike-counter width; counters saturate at 2^CNT_W−1
- V_W, 16, membrane width, signed 3.13

Ports (reset is asynchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset
- start  in  1  single-cycle pulse that begins a new image; clears all counters
- s_valid  in  1  s_in and v_in are valid this cycle
- s_ready  out  1  high only in ACCUM; a beat transfers when s_valid && s_ready
- s_in  in  N_CLASS  spike per class for the current timestep
- v_in  in  N_CLASS*V_W  membrane per class; class i at [V_W*(i+1)-1 : V_W*i]
- busy  out  1  high in ACCUM or SCAN
- done  out  1  one-cycle pulse; result is valid
- class_id  out  4  winning class; held until the next done
- class_cnt  out  CNT_W  spike count of the winner; held with class_id

## Operation

- States: IDLE, ACCUM, SCAN.
- **IDLE**
  - start → clear all cnt[i] and step; go to ACCUM.
  - s_valid is ignored.
- **ACCUM**
  - Each transferred beat: cnt[i] ← min(cnt[i]+s_in[i], 2^CNT_W−1); step++.
  - The beat with step==T_STEPS−1 also latches v_in into v_last and goes to SCAN. The best-candidate register is initialised from class 0 and idx←1.
  - Cycles with s_valid low change nothing.
- **SCAN**
  - One class per cycle, idx=1..N_CLASS−1.
  - Candidate idx replaces best if cnt[idx] > best_cnt, or cnt[idx]==best_cnt and signed v_last[idx] > best_v.
  - On a full tie (equal count and membrane), the lower index wins.
  - On the cycle processing idx==N_CLASS−1: class_id/class_cnt ← final best, done←1, go to IDLE.
- **start precedence**
  - start in ACCUM or SCAN aborts the current image, clears counters and re-enters ACCUM. No done is produced for the aborted image.
  - When start and s_valid are asserted in the same cycle, that beat is not counted.
- **Reset** (any time, including mid-ACCUM/SCAN)
  - State IDLE; all cnt, step, idx and v_last cleared.
  - Outputs: s_ready=0, busy=0, done=0, class_id=0, class_cnt=0.
- **Width rules**
  - Counter add is CNT_W wide with a saturation check; no wrap.
  - Membrane compare is a V_W-bit signed comparison.
  - step is $clog2(T_STEPS) bits.

## Timing

- s_ready rises in the cycle after start is sampled.
- Latency from the edge accepting the last beat (E0) to done high: N_CLASS−1 edges. With N_CLASS=10, done is registered at E9.
- done is high for exactly one cycle. class_id/class_cnt update on the same edge as done rises.
- busy falls on the same edge that raises done.
- Minimum image period: T_STEPS + N_CLASS cycles, including the start cycle.
- start may be asserted in the cycle done is high; this begins the next image with no bubble.

## Structure

- Package fc_dec_pkg holds:
  - the state enum (IDLE, ACCUM, SCAN)
  - default N_CLASS, T_STEPS, CNT_W, V_W
  - the class_id width constant (4)
- Sub-module spike_cnt_sat: one CNT_W saturating counter with clear and increment-enable, instantiated N_CLASS times.
- The comparator/scan datapath stays in the top module.

## Test plan

- **Reset mid-ACCUM:** after 3 beats, pulse rst → all outputs 0, s_ready 0. A new start then needs a full 8 beats before SCAN.
- **Single winner:** s_in=10'b0000001000 for 8 beats → done 9 cycles after the last beat, class_id=3, class_cnt=8.
- **Tie-break:**
  - classes 2 and 7 at 5 spikes each, v[7]=0x1000, v[2]=0x0800 → class_id=7.
  - Same counts with equal membranes → class_id=2.
  - Same counts with v[2]=0x0000, v[7]=0xFF00 (negative) → class_id=2.
- **Saturation:** CNT_W=3, class 5 spikes all 8 beats, class 1 spikes 7 beats → cnt[5]=7 (no wrap), tie broken by membrane. With equal membranes → class_id=1, class_cnt=7.
- **Gapped valid:** s_valid toggled every other cycle, s_in all-ones on valid beats only → every class ends with count 8. Full tie → class_id=0, done 8+7+9 cycles after start.
- **Abort:** start re-pulsed after 4 beats of class 6 spiking → no done. Then 8 beats of class 9 spiking → class_id=9, class_cnt=8.
